// File: rtl/pipeline_hazard_sequencer_if.sv
// Pipeline hazard control bundle: hazard inputs from the datapath and stage controls back to it.
// Latency: carries no storage; all signals are plain wires.
// Backpressure: none at this level; the sequencer applies stalls through the enables.
// master = pipeline datapath side, slave = hazard sequencer side.
interface pipeline_hazard_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // hazard sources
    logic              id_ex_memread;
    logic [4:0]        id_ex_rd;
    logic [4:0]        if_id_rs_a;
    logic [4:0]        if_id_rs_b;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              dmem_req;
    logic              dmem_ack;
    // stage controls
    logic              pc_write_en;
    logic              pc_sel_branch;
    logic [ADDR_W-1:0] pc_branch_addr;
    logic              if_id_write_en;
    logic              if_id_flush;
    logic              id_ex_write_en;
    logic              id_ex_flush;
    logic              ex_mem_write_en;
    logic              mem_wb_bubble;
    // status
    logic              mem_timeout_err;
    logic [CNT_W-1:0]  loaduse_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  memwait_cnt;

    modport master (
        output id_ex_memread, id_ex_rd, if_id_rs_a, if_id_rs_b,
               branch_taken, branch_target, dmem_req, dmem_ack,
        input  pc_write_en, pc_sel_branch, pc_branch_addr,
               if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
               ex_mem_write_en, mem_wb_bubble,
               mem_timeout_err, loaduse_cnt, flush_cnt, memwait_cnt
    );

    modport slave (
        input  id_ex_memread, id_ex_rd, if_id_rs_a, if_id_rs_b,
               branch_taken, branch_target, dmem_req, dmem_ack,
        output pc_write_en, pc_sel_branch, pc_branch_addr,
               if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
               ex_mem_write_en, mem_wb_bubble,
               mem_timeout_err, loaduse_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard sequencer for the 5-stage core: load-use stall, ID branch redirect, data-memory freeze.
// Latency: stage controls are combinational (Mealy) in the same cycle; counters/flags update on the next edge.
// Backpressure: an outstanding dmem access freezes every stage; a branch seen while frozen is replayed afterwards.
// Ports: clk, rst_n (async active-low) and the slave modport of pipeline_hazard_sequencer_if.
module pipeline_hazard_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                      clk,
    input logic                      rst_n,
    pipeline_hazard_sequencer_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic              branch_pending_q, branch_pending_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_err_q, mem_timeout_err_d;
    logic [CNT_W-1:0]  loaduse_cnt_q, loaduse_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  memwait_cnt_q, memwait_cnt_d;

    logic              load_use;
    logic              freeze;
    logic              inc_loaduse, inc_flush, inc_memwait;

    // raw controls, forced to zero while reset is asserted
    logic              pc_write_en_c, pc_sel_branch_c, if_id_write_en_c, if_id_flush_c;
    logic              id_ex_write_en_c, id_ex_flush_c, ex_mem_write_en_c, mem_wb_bubble_c;
    logic [ADDR_W-1:0] pc_branch_addr_c;

    always_comb begin
        load_use = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
                   ((bus.id_ex_rd == bus.if_id_rs_a) || (bus.id_ex_rd == bus.if_id_rs_b));
        // The RUN term covers the request cycle itself: that cycle is already a wait cycle.
        freeze   = ((state_q == MEM_WAIT) && !bus.dmem_ack) ||
                   ((state_q == RUN) && bus.dmem_req && !bus.dmem_ack);
    end

    always_comb begin
        state_d           = state_q;
        branch_pending_d  = branch_pending_q;
        pend_addr_d       = pend_addr_q;
        wait_cnt_d        = wait_cnt_q;
        mem_timeout_err_d = mem_timeout_err_q;
        inc_loaduse       = 1'b0;
        inc_flush         = 1'b0;
        inc_memwait       = 1'b0;

        pc_write_en_c     = 1'b1;
        pc_sel_branch_c   = 1'b0;
        pc_branch_addr_c  = '0;
        if_id_write_en_c  = 1'b1;
        if_id_flush_c     = 1'b0;
        id_ex_write_en_c  = 1'b1;
        id_ex_flush_c     = 1'b0;
        ex_mem_write_en_c = 1'b1;
        mem_wb_bubble_c   = 1'b0;

        if (freeze) begin
            pc_write_en_c     = 1'b0;
            if_id_write_en_c  = 1'b0;
            id_ex_write_en_c  = 1'b0;
            ex_mem_write_en_c = 1'b0;
            mem_wb_bubble_c   = 1'b1;
            inc_memwait       = 1'b1;
            // Only the first redirect seen during a freeze is kept; the ID
            // instruction is frozen, so later assertions are the same branch.
            if (bus.branch_taken && !branch_pending_q) begin
                branch_pending_d = 1'b1;
                pend_addr_d      = bus.branch_target;
            end
        end else if (branch_pending_q) begin
            // Replay the held redirect; whatever now sits in ID is stale.
            pc_sel_branch_c  = 1'b1;
            pc_branch_addr_c = pend_addr_q;
            if_id_flush_c    = 1'b1;
            id_ex_flush_c    = 1'b1;
            branch_pending_d = 1'b0;
            inc_flush        = 1'b1;
        end else if (load_use) begin
            // Branch in ID waits; it re-resolves once the load data is forwardable.
            pc_write_en_c    = 1'b0;
            if_id_write_en_c = 1'b0;
            id_ex_flush_c    = 1'b1;
            inc_loaduse      = 1'b1;
        end else if (bus.branch_taken) begin
            pc_sel_branch_c  = 1'b1;
            pc_branch_addr_c = bus.branch_target;
            if_id_flush_c    = 1'b1;
            inc_flush        = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WC_W'(MEM_TIMEOUT - 1)) begin
                    // This cycle is the MEM_TIMEOUT-th frozen one: abort the access.
                    state_d           = RUN;
                    wait_cnt_d        = '0;
                    mem_timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        loaduse_cnt_d = loaduse_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (inc_loaduse && (loaduse_cnt_q != '1)) loaduse_cnt_d = loaduse_cnt_q + CNT_W'(1);
        if (inc_flush   && (flush_cnt_q   != '1)) flush_cnt_d   = flush_cnt_q   + CNT_W'(1);
        if (inc_memwait && (memwait_cnt_q != '1)) memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= RUN;
            branch_pending_q  <= 1'b0;
            pend_addr_q       <= '0;
            wait_cnt_q        <= '0;
            mem_timeout_err_q <= 1'b0;
            loaduse_cnt_q     <= '0;
            flush_cnt_q       <= '0;
            memwait_cnt_q     <= '0;
        end else begin
            state_q           <= state_d;
            branch_pending_q  <= branch_pending_d;
            pend_addr_q       <= pend_addr_d;
            wait_cnt_q        <= wait_cnt_d;
            mem_timeout_err_q <= mem_timeout_err_d;
            loaduse_cnt_q     <= loaduse_cnt_d;
            flush_cnt_q       <= flush_cnt_d;
            memwait_cnt_q     <= memwait_cnt_d;
        end
    end

    // Controls are gated by rst_n so the pipeline holds still during reset.
    assign bus.pc_write_en     = rst_n & pc_write_en_c;
    assign bus.pc_sel_branch   = rst_n & pc_sel_branch_c;
    assign bus.pc_branch_addr  = rst_n ? pc_branch_addr_c : '0;
    assign bus.if_id_write_en  = rst_n & if_id_write_en_c;
    assign bus.if_id_flush     = rst_n & if_id_flush_c;
    assign bus.id_ex_write_en  = rst_n & id_ex_write_en_c;
    assign bus.id_ex_flush     = rst_n & id_ex_flush_c;
    assign bus.ex_mem_write_en = rst_n & ex_mem_write_en_c;
    assign bus.mem_wb_bubble   = rst_n & mem_wb_bubble_c;
    assign bus.mem_timeout_err = mem_timeout_err_q;
    assign bus.loaduse_cnt     = loaduse_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
    assign bus.memwait_cnt     = memwait_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer with MEM_TIMEOUT=4.
// Expected stage controls are queued as each step is driven and compared at the following falling edge.
// Counters and the timeout flag are checked against bench-side expected values after the clock edge.
module tb_pipeline_hazard_sequencer;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    // control vector order: pc_we, pc_sel, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_bub
    localparam logic [7:0] C_NORM = 8'b1010_1010;
    localparam logic [7:0] C_FRZ  = 8'b0000_0001;
    localparam logic [7:0] C_LU   = 8'b0000_1110;
    localparam logic [7:0] C_BR   = 8'b1111_1010;
    localparam logic [7:0] C_PEND = 8'b1111_1110;
    localparam logic [7:0] C_ZERO = 8'b0000_0000;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [7:0]        exp_ctrl_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    string             exp_tag_q[$];

    pipeline_hazard_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MEM_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_head();
        logic [7:0]        e_c;
        logic [ADDR_W-1:0] e_a;
        string             t;
        logic [7:0]        o_c;
        if (exp_ctrl_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard empty");
            return;
        end
        e_c = exp_ctrl_q.pop_front();
        e_a = exp_addr_q.pop_front();
        t   = exp_tag_q.pop_front();
        o_c = {bus.pc_write_en, bus.pc_sel_branch, bus.if_id_write_en, bus.if_id_flush,
               bus.id_ex_write_en, bus.id_ex_flush, bus.ex_mem_write_en, bus.mem_wb_bubble};
        tests++;
        assert (o_c === e_c) else begin
            fails++;
            $error("FAIL %s ctrl observed=%b expected=%b", t, o_c, e_c);
        end
        tests++;
        assert (bus.pc_branch_addr === e_a) else begin
            fails++;
            $error("FAIL %s pc_branch_addr observed=%h expected=%h", t, bus.pc_branch_addr, e_a);
        end
    endtask

    // Inputs are already driven (just after a rising edge); check this cycle, then advance.
    task automatic step(input logic [7:0] ec, input logic [ADDR_W-1:0] ea, input string tag);
        exp_ctrl_q.push_back(ec);
        exp_addr_q.push_back(ea);
        exp_tag_q.push_back(tag);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnts(input string tag, input int lu, input int fl, input int mw, input logic err);
        chk({tag, " loaduse_cnt"}, 32'(bus.loaduse_cnt), 32'(lu));
        chk({tag, " flush_cnt"},   32'(bus.flush_cnt),   32'(fl));
        chk({tag, " memwait_cnt"}, 32'(bus.memwait_cnt), 32'(mw));
        chk({tag, " mem_timeout_err"}, 32'(bus.mem_timeout_err), 32'(err));
    endtask

    task automatic idle();
        bus.id_ex_memread = 1'b0;
        bus.id_ex_rd      = 5'd0;
        bus.if_id_rs_a    = 5'd0;
        bus.if_id_rs_b    = 5'd0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.dmem_req      = 1'b0;
        bus.dmem_ack      = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        // Reset: stimulus that would otherwise act must stay masked.
        rst_n = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0400;
        #3;
        exp_ctrl_q.push_back(C_ZERO); exp_addr_q.push_back('0); exp_tag_q.push_back("in_reset");
        compare_head();
        chk_cnts("reset", 0, 0, 0, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(C_NORM, '0, "idle_run");

        // Load-use on source B.
        bus.id_ex_memread = 1'b1; bus.id_ex_rd = 5'd5; bus.if_id_rs_a = 5'd1; bus.if_id_rs_b = 5'd5;
        step(C_LU, '0, "loaduse_rs_b");
        chk_cnts("after_loaduse", 1, 0, 0, 1'b0);

        // Load into x0 never stalls.
        bus.id_ex_rd = 5'd0; bus.if_id_rs_a = 5'd0; bus.if_id_rs_b = 5'd0;
        step(C_NORM, '0, "loaduse_x0");
        idle();

        // Taken branch.
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0400;
        step(C_BR, 32'h0000_0400, "branch");
        chk_cnts("after_branch", 1, 1, 0, 1'b0);

        // Branch with simultaneous load-use on source A: stall wins.
        bus.id_ex_memread = 1'b1; bus.id_ex_rd = 5'd7; bus.if_id_rs_a = 5'd7;
        step(C_LU, '0, "branch_vs_loaduse");
        chk_cnts("after_br_lu", 2, 1, 0, 1'b0);
        idle();

        // Memory access with ack three cycles after the request.
        bus.dmem_req = 1'b1;
        step(C_FRZ, '0, "memwait_c1");
        step(C_FRZ, '0, "memwait_c2");
        step(C_FRZ, '0, "memwait_c3");
        bus.dmem_ack = 1'b1;
        step(C_NORM, '0, "memwait_ack");
        idle();
        step(C_NORM, '0, "memwait_back_run");
        chk_cnts("after_memwait", 2, 1, 3, 1'b0);

        // Zero-wait access.
        bus.dmem_req = 1'b1; bus.dmem_ack = 1'b1;
        step(C_NORM, '0, "zero_wait");
        idle();
        step(C_NORM, '0, "zero_wait_next");
        chk_cnts("after_zero_wait", 2, 1, 3, 1'b0);

        // Branch arriving during a freeze; a second target must not overwrite the first.
        bus.dmem_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0080;
        step(C_FRZ, '0, "frz_br_c1");
        bus.branch_target = 32'h0000_0900;
        step(C_FRZ, '0, "frz_br_c2");
        bus.branch_taken = 1'b0; bus.branch_target = '0;
        step(C_FRZ, '0, "frz_br_c3");
        // Ack cycle with a live load-use present: the pending redirect still wins.
        bus.dmem_req = 1'b0; bus.dmem_ack = 1'b1;
        bus.id_ex_memread = 1'b1; bus.id_ex_rd = 5'd3; bus.if_id_rs_a = 5'd3;
        step(C_PEND, 32'h0000_0080, "frz_br_replay");
        idle();
        step(C_NORM, '0, "frz_br_after");
        chk_cnts("after_frz_branch", 2, 2, 6, 1'b0);

        // Timeout: request held with no ack.
        bus.dmem_req = 1'b1;
        step(C_FRZ, '0, "timeout_c1");
        step(C_FRZ, '0, "timeout_c2");
        step(C_FRZ, '0, "timeout_c3");
        chk("timeout_err_before", 32'(bus.mem_timeout_err), 32'd0);
        step(C_FRZ, '0, "timeout_c4");
        chk("timeout_err_set", 32'(bus.mem_timeout_err), 32'd1);
        bus.dmem_req = 1'b0;
        step(C_NORM, '0, "timeout_back_run");
        step(C_NORM, '0, "timeout_idle");
        chk_cnts("after_timeout", 2, 2, 10, 1'b1);

        // Async reset in MEM_WAIT with a branch pending.
        bus.dmem_req = 1'b1;
        step(C_FRZ, '0, "rst_setup_c1");
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0123;
        step(C_FRZ, '0, "rst_setup_c2");
        #2;
        rst_n = 1'b0;
        #1;
        exp_ctrl_q.push_back(C_ZERO); exp_addr_q.push_back('0); exp_tag_q.push_back("midcycle_reset");
        compare_head();
        chk_cnts("midcycle_reset", 0, 0, 0, 1'b0);
        idle();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(C_NORM, '0, "post_reset_c1");
        step(C_NORM, '0, "post_reset_c2");
        chk_cnts("post_reset", 0, 0, 0, 1'b0);

        tests++;
        assert (exp_ctrl_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_ctrl_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Sequential pipeline-control block for the 5-stage core. It combines load-use detection, ID-stage branch redirect and multi-cycle data-memory waits into one set of per-stage write-enable, flush and PC-select controls. A small FSM freezes the pipeline during memory waits, and holds any branch redirect that arrives during a freeze. Saturating performance counters record stall, flush and wait cycles.

Parameters:
ADDR_W, 32, PC/branch target width
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error abort (>=2)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_ex_memread  in  1  instruction in EX is a load
id_ex_rd  in  5  destination register of instruction in EX
if_id_rs_a  in  5  source A of instruction in ID
if_id_rs_b  in  5  source B of instruction in ID
branch_taken  in  1  ID resolves a taken branch this cycle
branch_target  in  ADDR_W  target for branch_taken
dmem_req  in  1  MEM stage issues a data-memory access this cycle
dmem_ack  in  1  data memory completes the access
pc_write_en  out  1  PC register load enable
pc_sel_branch  out  1  PC next value = pc_branch_addr
pc_branch_addr  out  ADDR_W  redirect target; 0 when pc_sel_branch=0
if_id_write_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID becomes bubble
id_ex_write_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX becomes bubble
ex_mem_write_en  out  1  EX/MEM register enable
mem_wb_bubble  out  1  MEM/WB loads a bubble
mem_timeout_err  out  1  sticky, set on MEM_WAIT timeout
loaduse_cnt  out  CNT_W  load-use bubble cycles
flush_cnt  out  CNT_W  redirects applied
memwait_cnt  out  CNT_W  frozen cycles

Behaviour:
- States: RUN, MEM_WAIT. Control outputs are Mealy: combinational from state, pending registers and inputs. Counters, state, pending and error flag are registered.
- Reset (rst_n low, async): state=RUN, branch_pending=0, pend_addr=0, wait_cnt=0, all counters 0, mem_timeout_err=0. While rst_n is low, all enables, flushes, pc_sel_branch and mem_wb_bubble are 0 and pc_branch_addr=0.
- Default outputs in RUN with no event: all *_write_en=1, flushes/bubble/pc_sel_branch=0.
- load_use = id_ex_memread & (id_ex_rd!=0) & (id_ex_rd==if_id_rs_a | id_ex_rd==if_id_rs_b). Register x0 is never a hazard.
- freeze = (state==MEM_WAIT & !dmem_ack) | (state==RUN & dmem_req & !dmem_ack).
- Priority 1, freeze:
  - pc_write_en, if_id_write_en, id_ex_write_en and ex_mem_write_en are 0; mem_wb_bubble=1.
  - load-use and branch are not acted on.
  - If branch_taken and branch_pending=0: latch branch_pending=1, pend_addr=branch_target.
  - memwait_cnt increments.
- RUN + dmem_req + !dmem_ack: next state MEM_WAIT, wait_cnt=1. A same-cycle ack (zero-wait) never enters MEM_WAIT.
- MEM_WAIT:
  - On dmem_ack: this cycle is unfrozen (priorities 2-4 apply), next state RUN, wait_cnt=0.
  - Otherwise wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT: set mem_timeout_err, next state RUN, wait_cnt=0.
- Priority 2, branch_pending=1 (not frozen):
  - pc_sel_branch=1, pc_branch_addr=pend_addr, if_id_flush=1, id_ex_flush=1.
  - Clear branch_pending; flush_cnt increments.
  - Live branch_taken and load_use are ignored this cycle; the stale ID instruction is flushed.
- Priority 3, load_use:
  - pc_write_en=0, if_id_write_en=0, id_ex_flush=1; loaduse_cnt increments.
  - branch_taken is ignored this cycle. The branch stays in ID and re-resolves next cycle.
- Priority 4, branch_taken:
  - pc_sel_branch=1, pc_branch_addr=branch_target, if_id_flush=1; flush_cnt increments.
- Counters saturate at all-ones and never wrap.
- mem_timeout_err clears only on reset.
- Reset asserted mid-MEM_WAIT or with a pending branch discards both.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs_b=5 for 1 cycle -> pc_write_en=0, if_id_write_en=0, id_ex_flush=1 that cycle; loaduse_cnt=1. Repeat with rd=0 -> no stall.
- Branch: branch_taken=1, target=0x0000_0400 -> pc_sel_branch=1, pc_branch_addr=0x400, if_id_flush=1 same cycle; flush_cnt=1. Simultaneous load-use -> stall only, no redirect.
- Memory wait: dmem_req=1, ack arrives 3 cycles later -> 3 frozen cycles (all enables 0, mem_wb_bubble=1), memwait_cnt=3, ack cycle unfrozen, state RUN. Zero-wait ack -> no freeze.
- Branch during freeze: branch_taken=1 (target 0x80) in MEM_WAIT cycle 1, ack at cycle 4 -> first unfrozen cycle has pc_sel_branch=1, pc_branch_addr=0x80, if_id_flush=1, id_ex_flush=1; flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_req held with no ack -> mem_timeout_err=1 after the 4th wait cycle, state RUN, flag sticky until rst_n low.
- Async reset mid-MEM_WAIT with branch pending -> outputs zero immediately, counters 0; after release, first cycle is normal RUN with no redirect.
